// File: rtl/tlul_apb_pkg.sv
// -----------------------------------------------------------------------------
// tlul_apb_pkg
// Shared types for the TL-UL to APB3 master bridge: FSM state encoding, the
// captured-request record and the default ACCESS-phase timeout.
// -----------------------------------------------------------------------------
package tlul_apb_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  // Request as latched on acceptance; err also accumulates APB-side errors.
  typedef struct packed {
    logic [tlul_pkg::TL_AW-1:0]  addr;
    logic                        write;
    logic [tlul_pkg::TL_DW-1:0]  wdata;
    logic [tlul_pkg::TL_DBW-1:0] strb;
    logic [tlul_pkg::TL_AIW-1:0] source;
    logic [tlul_pkg::TL_SZW-1:0] size;
    logic                        err;
  } req_t;

endpackage

// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// Minimal TL-UL type and integrity-helper package used by the bridge and its
// bench. Mirrors the OpenTitan channel layout (32-bit address/data, 8-bit
// source, 2-bit size). The integrity helpers are a compact 7-bit XOR fold
// standing in for the full SECDED encoder; callers only rely on the fact that
// any single-bit change in a covered field changes the code.
// -----------------------------------------------------------------------------
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // Bit i of the input folds into code bit (i mod 7).
  function automatic logic [6:0] intg_fold(input logic [63:0] d);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[i % 7] = r[i % 7] ^ d[i];
    end
    return r;
  endfunction

  // Command integrity covers opcode, mask and address.
  function automatic logic [6:0] get_cmd_intg(input tl_h2d_t tl);
    return intg_fold({25'h0, tl.a_opcode, tl.a_mask, tl.a_address});
  endfunction

  function automatic logic [6:0] get_data_intg(input logic [TL_DW-1:0] data);
    return intg_fold({32'h0, data});
  endfunction

  // Response integrity covers opcode, size and error.
  function automatic logic [6:0] get_rsp_intg(input tl_d2h_t tl);
    return intg_fold({58'h0, tl.d_opcode, tl.d_size, tl.d_error});
  endfunction

endpackage

// File: rtl/tlul_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tlul_apb_master_bridge
// TL-UL device-side responder that converts single-beat Get / PutFullData /
// PutPartialData requests into APB3 master transfers, one at a time, and
// returns an integrity-protected D-channel response.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   tl_i             TL-UL A channel plus d_ready
//   tl_o             TL-UL D channel plus a_ready
//   apb_paddr..pstrb registered APB3 master outputs
//   apb_prdata       APB read data
//   apb_pready       APB ready (only looked at during ACCESS)
//   apb_pslverr      APB slave error (sampled with pready)
//
// Malformed requests (bad opcode, size, full-put mask or integrity) skip the
// APB bus entirely and go straight to an error response.
// -----------------------------------------------------------------------------
module tlul_apb_master_bridge
  import tlul_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  tlul_pkg::tl_h2d_t  tl_i,
  output tlul_pkg::tl_d2h_t  tl_o,
  output logic [ADDR_W-1:0]  apb_paddr,
  output logic               apb_psel,
  output logic               apb_penable,
  output logic               apb_pwrite,
  output logic [31:0]        apb_pwdata,
  output logic [3:0]         apb_pstrb,
  input  logic [31:0]        apb_prdata,
  input  logic               apb_pready,
  input  logic               apb_pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  req_t              req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              a_ready_q, psel_q, penable_q;

  logic              req_is_get, req_is_put, req_err;
  logic              accept, timed_out;
  tlul_pkg::tl_d2h_t rsp;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    req_is_get = (tl_i.a_opcode == tlul_pkg::Get);
    req_is_put = (tl_i.a_opcode == tlul_pkg::PutFullData) ||
                 (tl_i.a_opcode == tlul_pkg::PutPartialData);
    req_err    = !(req_is_get || req_is_put)
               || (tl_i.a_size > 2'd2)
               || ((tl_i.a_opcode == tlul_pkg::PutFullData) && (tl_i.a_mask != 4'hF))
               || (tl_i.a_user.cmd_intg != tlul_pkg::get_cmd_intg(tl_i))
               || (req_is_put &&
                   (tl_i.a_user.data_intg != tlul_pkg::get_data_intg(tl_i.a_data)));
  end

  assign accept    = (state_q == IDLE) && a_ready_q && tl_i.a_valid;
  // pready has priority: a ready on the threshold cycle is a normal completion.
  assign timed_out = (TIMEOUT_CYCLES != 0) && (state_q == ACCESS) &&
                     !apb_pready && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets its default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb_pready || timed_out) state_d = RESP;
      RESP:    if (tl_i.d_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      a_ready_q <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_ready_q <= (state_d == IDLE);
      psel_q    <= (state_d inside {SETUP, ACCESS});
      penable_q <= (state_d == ACCESS);
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture, APB read capture and ACCESS-phase counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        req_q.addr   <= {tl_i.a_address[tlul_pkg::TL_AW-1:2], 2'b00};
        req_q.write  <= !req_is_get;
        req_q.wdata  <= req_is_get ? '0 : tl_i.a_data;
        req_q.strb   <= req_is_get ? '0 : tl_i.a_mask;
        req_q.source <= tl_i.a_source;
        req_q.size   <= tl_i.a_size;
        req_q.err    <= req_err;
        rdata_q      <= '0;
      end else if (state_q == ACCESS) begin
        if (apb_pready) begin
          req_q.err <= req_q.err | apb_pslverr;
          rdata_q   <= (!req_q.write && !apb_pslverr) ? apb_prdata : '0;
        end else if (timed_out) begin
          req_q.err <= 1'b1;
        end
      end

      if ((state_q == ACCESS) && (state_d == ACCESS)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign apb_paddr   = req_q.addr[ADDR_W-1:0];
  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = req_q.write;
  assign apb_pwdata  = req_q.wdata;
  assign apb_pstrb   = req_q.strb;

  // D fields are only driven in RESP; elsewhere the whole channel reads zero.
  always_comb begin
    rsp         = '0;
    rsp.a_ready = a_ready_q;
    if (state_q == RESP) begin
      rsp.d_valid  = 1'b1;
      rsp.d_opcode = req_q.write ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;
      rsp.d_size   = req_q.size;
      rsp.d_source = req_q.source;
      rsp.d_data   = rdata_q;
      rsp.d_error  = req_q.err;
    end
    rsp.d_user.rsp_intg  = tlul_pkg::get_rsp_intg(rsp);
    rsp.d_user.data_intg = tlul_pkg::get_data_intg(rsp.d_data);
  end

  assign tl_o = rsp;

  logic unused_sig;
  assign unused_sig = ^{tl_i.a_param, req_q.addr};

endmodule

// File: doc/tlul_apb_master_bridge.md
Name: tlul_apb_master_bridge

Overview:
- TL-UL device-side responder that turns single-beat TL-UL requests into APB3 master transfers, one outstanding transaction at a time.
- Lets OpenTitan-style TL-UL hosts on the Ariane tile reach legacy APB peripherals (timers, UART, ESP APB slaves).
- Completes each APB transfer, then returns a TL-UL D-channel response with integrity fields.

Parameters:
- TIMEOUT_CYCLES, 1024, max ACCESS-phase cycles waiting for pready before an error response; 0 disables the timeout.
- ADDR_W, 32, width of paddr; taken from the low bits of a_address.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- tl_i  input  tlul_pkg::tl_h2d_t  TL-UL request (A channel plus d_ready)
- tl_o  output  tlul_pkg::tl_d2h_t  TL-UL response (D channel plus a_ready)
- apb_paddr  output  ADDR_W  APB address
- apb_psel  output  1  APB select
- apb_penable  output  1  APB enable
- apb_pwrite  output  1  APB write
- apb_pwdata  output  32  APB write data
- apb_pstrb  output  4  APB byte strobes
- apb_prdata  input  32  APB read data
- apb_pready  input  1  APB ready
- apb_pslverr  input  1  APB slave error

Behaviour:
- Reset: clk and rstn as above; reset is asynchronous, active-low. While rstn is low:
  - all APB outputs are 0;
  - tl_o.d_valid is 0 and tl_o.a_ready is 0;
  - the FSM is in IDLE and the timeout counter is 0.
  Asserting reset mid-transfer drops psel/penable in the same cycle and discards the pending response.
- FSM states and transitions:
  - IDLE: a_ready=1. On a_valid, capture address, opcode, size, source, mask, data and the error flag; go to SETUP if no error, else RESP.
  - SETUP: psel=1, penable=0. Always goes to ACCESS on the next cycle.
  - ACCESS: psel=1, penable=1; counter increments each cycle.
    - On pready: capture prdata/pslverr, go to RESP.
    - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without pready: go to RESP with error.
  - RESP: d_valid=1 with all D fields stable. When d_valid and d_ready are both high, go to IDLE.
- a_ready is 1 only in IDLE, so back-to-back requests cost at least 4 cycles each: accept, SETUP, ACCESS, RESP.
- Request mapping:
  - Get gives pwrite=0 and pstrb=0.
  - PutFullData and PutPartialData give pwrite=1, pwdata=a_data, pstrb=a_mask.
  - paddr = a_address[ADDR_W-1:0] with bits [1:0] forced to 0.
  - APB outputs are registered and hold their values from SETUP through ACCESS.
- Errors raised without an APB access (go straight IDLE to RESP, d_error=1):
  - unsupported opcode;
  - a_size>2;
  - PutFullData with a_mask not equal to 4'hF;
  - cmd integrity mismatch, i.e. a_user.cmd_intg differs from tlul_pkg::get_cmd_intg(tl_i);
  - data integrity mismatch on Puts.
- Response fields:
  - d_opcode is AccessAckData for Get, AccessAck otherwise.
  - d_source and d_size echo the captured request.
  - d_data is the captured prdata for a successful Get, 0 otherwise.
  - d_error = pslverr | timeout | request error.
  - d_user rsp_intg/data_intg are computed from the registered response with the tlul_pkg helpers.
  - d_param, d_sink = 0.
- Simultaneous events:
  - pready arriving on the same cycle as the timeout threshold counts as a normal completion; the timeout does not fire.
  - An APB-side pready seen outside ACCESS is ignored.
  - A d_ready that stays low holds RESP indefinitely; no new request is accepted meanwhile.

Decomposition:
- Package tlul_apb_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS, RESP);
  - the captured-request struct (addr, write, wdata, strb, source, size, err);
  - the default TIMEOUT constant.
- Single module; integrity computation reuses tlul_pkg functions, no extra sub-module.

Test Plan:
- Get to 0x100, slave pready on the first ACCESS cycle with prdata=0xDEADBEEF:
  - psel rises 1 cycle after acceptance, penable 1 cycle later;
  - the D response is AccessAckData, d_data=0xDEADBEEF, d_error=0, source echoed.
- PutPartialData a_mask=4'b0011 data=0x12345678 to 0x204:
  - pwrite=1, pstrb=4'b0011, paddr=0x204;
  - slave holds 3 wait states; the response AccessAck comes after pready, d_error=0.
- Get with slave pslverr=1: d_error=1 and d_data=0.
- TIMEOUT_CYCLES=8, slave never readies:
  - psel/penable drop after 8 ACCESS cycles;
  - the response has d_error=1 and the next request is accepted.
- Corrupted cmd_intg, and separately a_size=3:
  - no psel pulse at any point;
  - the error response arrives the cycle after acceptance.
- Hold d_ready=0 for 5 cycles during RESP, then pulse rstn low mid-ACCESS on the next transfer:
  - D fields stay stable and a_ready=0 throughout the stall;
  - on reset, all outputs go to 0 immediately and the bridge accepts a fresh request after release.
